// File: rtl/load_extract_unit_if.sv
// rtl/load_extract_unit_if.sv - load command, data-memory read port and result bundle for load_extract_unit
interface load_extract_unit_if;
  logic        start;
  logic [31:0] adr;
  logic [2:0]  slctrl;
  logic        sign;
  logic [31:0] rt_old;
  logic        mem_req;
  logic [31:0] mem_adr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] dout;

  modport master (
    output start, adr, slctrl, sign, rt_old, mem_ack, mem_rdata,
    input  mem_req, mem_adr, busy, done, err, dout
  );

  modport slave (
    input  start, adr, slctrl, sign, rt_old, mem_ack, mem_rdata,
    output mem_req, mem_adr, busy, done, err, dout
  );
endinterface

// File: rtl/load_extract_unit.sv
// rtl/load_extract_unit.sv - MEM-stage load unit: one aligned word read, then extract/extend/LWL-LWR merge
// Optional REQ timeout is enabled by defining LOADCALC_TIMEOUT_EN.
module load_extract_unit (
  input logic                clk,
  input logic                reset_n,
  load_extract_unit_if.slave bus
);

  localparam logic [2:0] SLWORD      = 3'd0;
  localparam logic [2:0] SLHALF      = 3'd1;
  localparam logic [2:0] SLBYTE      = 3'd2;
  localparam logic [2:0] SLWORDLEFT  = 3'd3;
  localparam logic [2:0] SLWORDRIGHT = 3'd4;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] rt_q, rt_d;
  logic [31:0] dout_q, dout_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        sign_q, sign_d;
  logic        err_q, err_d;
  logic        misaligned;
  logic [15:0] half;
  logic [7:0]  byt;
  logic [4:0]  lsh, rsh;
  logic [31:0] extracted;
`ifdef LOADCALC_TIMEOUT_EN
  logic [3:0]  cnt_q, cnt_d;
`endif

  // Alignment is judged on the incoming command, before anything is latched.
  always_comb begin
    misaligned = 1'b0;
    case (bus.slctrl)
      SLWORD:      misaligned = (bus.adr[1:0] != 2'b00);
      SLHALF:      misaligned = bus.adr[0];
      SLBYTE,
      SLWORDLEFT,
      SLWORDRIGHT: misaligned = 1'b0;
      default:     misaligned = 1'b1;
    endcase
  end

  // 3-b on two bits is ~b, so the LWL shift is the bit-inverted offset.
  always_comb begin
    half      = bus.mem_rdata[{adr_q[1], 4'b0000} +: 16];
    byt       = bus.mem_rdata[{adr_q[1:0], 3'b000} +: 8];
    lsh       = {~adr_q[1:0], 3'b000};
    rsh       = {adr_q[1:0], 3'b000};
    extracted = bus.mem_rdata;
    case (ctrl_q)
      SLHALF:      extracted = {{16{sign_q & half[15]}}, half};
      SLBYTE:      extracted = {{24{sign_q & byt[7]}}, byt};
      SLWORDLEFT:  extracted = (bus.mem_rdata << lsh) | (rt_q & ~(32'hFFFF_FFFF << lsh));
      SLWORDRIGHT: extracted = (bus.mem_rdata >> rsh) | (rt_q & ~(32'hFFFF_FFFF >> rsh));
      default:     extracted = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    rt_d    = rt_q;
    ctrl_d  = ctrl_q;
    sign_d  = sign_q;
    err_d   = err_q;
    dout_d  = dout_q;
`ifdef LOADCALC_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          adr_d  = bus.adr;
          rt_d   = bus.rt_old;
          ctrl_d = bus.slctrl;
          sign_d = bus.sign;
          if (misaligned) begin
            state_d = DONE;
            err_d   = 1'b1;
            dout_d  = 32'h0;
          end else begin
            state_d = REQ;
            err_d   = 1'b0;
          end
`ifdef LOADCALC_TIMEOUT_EN
          cnt_d = 4'h0;
`endif
        end
      end
      REQ: begin
        if (bus.mem_ack) begin
          state_d = DONE;
          err_d   = 1'b0;
          dout_d  = extracted;
`ifdef LOADCALC_TIMEOUT_EN
        end else if (cnt_q == 4'hF) begin
          state_d = DONE;
          err_d   = 1'b1;
          dout_d  = 32'h0;
        end else begin
          cnt_d = cnt_q + 4'd1;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      adr_q   <= 32'h0;
      rt_q    <= 32'h0;
      ctrl_q  <= 3'd0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= 32'h0;
`ifdef LOADCALC_TIMEOUT_EN
      cnt_q   <= 4'h0;
`endif
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      rt_q    <= rt_d;
      ctrl_q  <= ctrl_d;
      sign_q  <= sign_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
`ifdef LOADCALC_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.mem_req = (state_q == REQ);
  assign bus.mem_adr = {adr_q[31:2], 2'b00};
  assign bus.busy    = (state_q != IDLE) && (state_q != DONE);
  assign bus.done    = (state_q == DONE);
  assign bus.err     = err_q;
  assign bus.dout    = dout_q;

endmodule

// File: doc/load_extract_unit.md
# load_extract_unit

Multi-cycle data-memory load unit for the MIPS datapath's MEM stage; the read-side counterpart of the store formatter. It accepts a load command (address, `slword`/`slhalf`/`slbyte`/`slwordleft`/`slwordright` control code from define.v, sign flag, and the old rt value), issues one word-aligned read to data memory over a req/ack handshake, and extracts, sign/zero-extends or merges (LWL/LWR) the result. It asserts `busy` so the pipeline stalls until `done`.

## Interface
- No parameters; control encodings come from define.v.
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: launch a load; sampled only in IDLE.
- `adr` in 32: byte address of the load.
- `slctrl` in 3: `slword`/`slhalf`/`slbyte`/`slwordleft`/`slwordright`.
- `sign` in 1: 1 = sign-extend (LB/LH), 0 = zero-extend (LBU/LHU); ignored for word/LWL/LWR.
- `rt_old` in 32: current rt value, used for LWL/LWR merge.
- `mem_req` out 1: read request, held until ack.
- `mem_adr` out 32: `{adr_q[31:2],2'b00}`, stable while `mem_req`=1.
- `mem_ack` in 1: read data valid this cycle.
- `mem_rdata` in 32: read word, little-endian (byte 0 = bits 7:0).
- `busy` out 1: high in any state other than IDLE and DONE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid with `done`; misaligned or timed out.
- `dout` out 32: load result, held from `done` until the next accepted `start`.

## Operation
- States: IDLE, REQ, DONE.
- IDLE, `start`=1: latch `adr`, `slctrl`, `sign` and `rt_old`. Let b = `adr[1:0]`.
  - Misaligned: `slword` with b≠0, or `slhalf` with b[0]=1. Go to DONE with err=1 and dout=0. No memory request is issued.
  - Undefined `slctrl` code: treated as misaligned.
  - Otherwise go to REQ.
- REQ: `mem_req`=1. On `mem_ack`=1, capture the extracted result, then go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE. A `start` in DONE is ignored.
- `start` during REQ is ignored.
- Extraction from rdata R:
  - word: R.
  - half: R[16*b[1] +: 16], extended per `sign`.
  - byte: R[8*b +: 8], extended per `sign`.
  - LWL: `(R << 8*(3-b)) | (rt_old & ~(32'hFFFFFFFF << 8*(3-b)))`.
  - LWR: `(R >> 8*b) | (rt_old & ~(32'hFFFFFFFF >> 8*b))`.
- All shifts are 32-bit logical shifts; shift amount is 5 bits.

## Timing
- Reset values: `mem_req`=0, `mem_adr`=0, `busy`=0, `done`=0, `err`=0, `dout`=0, state=IDLE.
- Reset asserted mid-transaction drops `mem_req` immediately (asynchronous); the transaction is lost.
- `start` at edge N:
  - `mem_req`=1 and `busy`=1 from cycle N+1.
  - Ack at cycle N+k (k≥1): `done` and `dout` valid at cycle N+k+1.
  - Minimum latency is 2 cycles.
- Misaligned `start` at edge N: `done`=1 and `err`=1 at cycle N+1; `mem_req` never rises.
- `mem_ack` is ignored outside REQ. `mem_rdata` is sampled only when `mem_ack`=1.
- `err` is cleared on the next accepted `start`.

## Configuration
- Macro: `LOADCALC_TIMEOUT_EN`.
- Defined: a 4-bit counter runs in REQ. If 16 cycles pass in REQ without `mem_ack`:
  - `mem_req` drops, state goes to DONE with err=1 and dout=0.
  - An ack arriving on the 16th cycle wins over the timeout.
- Undefined: no counter; REQ waits indefinitely for `mem_ack`.

## Test plan
- LB: adr=0x1003, sign=1, rdata=0x80123456, immediate ack -> `done` 2 cycles after start, dout=0xFFFFFF80, err=0.
- LHU: adr=0x1002, sign=0, rdata=0xBEEF1234, ack after 3 wait cycles -> dout=0x0000BEEF, `busy` high throughout REQ, `done` one cycle.
- LWL/LWR: adr=0x1001, rdata=0xAABBCCDD, rt_old=0x11223344 -> LWL dout=0xCCDD3344; LWR dout=0x11AABBCC; `mem_adr`=0x1000 in both.
- Misaligned LW: adr=0x1002, `slword` -> `mem_req` stays 0, `done`=err=1 next cycle, dout=0; a second `start` in that DONE cycle is ignored.
- Reset mid-REQ: assert `reset_n`=0 while `mem_req`=1 -> `mem_req`, `busy`, `dout` go to 0 without waiting for a clock edge; after release, a new LW at 0x2000 with rdata=0x12345678 returns dout=0x12345678.
- Timeout (`LOADCALC_TIMEOUT_EN` defined): no ack for 16 cycles -> `done`=err=1, `mem_req` low. Same stimulus with the macro undefined -> `busy` stays high.
